// File: rtl/gf_bp_pkg.sv
// Shared constants and types for the fetch-stage branch predictor slice.
package gf_bp_pkg;
  localparam int          ADDR_LEN_DEF = 64;
  localparam int          INST_BYTES   = 4;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam int          BTB_IDX_DEF  = 6;
  localparam int          TAG_LEN_DEF  = 10;

  typedef struct packed {
    logic                    valid;
    logic [TAG_LEN_DEF-1:0]  tag;
    logic [ADDR_LEN_DEF-1:0] target;
  } btb_entry_t;
endpackage

// File: rtl/gf_btb.sv
// Direct-mapped branch target buffer: async-read lookup port, sync-write update port.
module gf_btb
  import gf_bp_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int BTB_IDX  = BTB_IDX_DEF,
  parameter int TAG_LEN  = TAG_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BTB_IDX-1:0]  lk_idx,
  input  logic [TAG_LEN-1:0]  lk_tag,
  output logic                lk_hit,
  output logic [ADDR_LEN-1:0] lk_target,
  input  logic                upd_en,
  input  logic [BTB_IDX-1:0]  upd_idx,
  input  logic [TAG_LEN-1:0]  upd_tag,
  input  logic [ADDR_LEN-1:0] upd_target
);
  localparam int ENTRIES = 1 << BTB_IDX;

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  valid_d;
  logic [TAG_LEN-1:0]  tag_mem [ENTRIES];
  logic [ADDR_LEN-1:0] tgt_mem [ENTRIES];

  always_comb begin
    valid_d = valid_q;
    if (upd_en) valid_d[upd_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag/target storage is only meaningful behind a valid bit, so it is never reset.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      tag_mem[upd_idx] <= upd_tag;
      tgt_mem[upd_idx] <= upd_target;
    end
  end

  assign lk_hit    = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lk_target = tgt_mem[lk_idx];
endmodule

// File: rtl/gf_npc.sv
// Fetch PC register, BTB/PHT next-PC selection and fetch->decode pipeline register.
module gf_npc
  import gf_bp_pkg::*;
#(
  parameter int                ADDR_LEN = ADDR_LEN_DEF,
  parameter logic [ADDR_LEN-1:0] RESET_PC = RESET_PC_DEF[ADDR_LEN-1:0],
  parameter int                BTB_IDX  = BTB_IDX_DEF,
  parameter int                TAG_LEN  = TAG_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [ADDR_LEN-1:0] i_redirect_pc,
  input  logic                i_upd_valid,
  input  logic [ADDR_LEN-1:0] i_upd_pc,
  input  logic                i_upd_taken,
  input  logic [ADDR_LEN-1:0] i_upd_target,
  output logic [ADDR_LEN-1:0] o_req_inst_addr,
  output logic                o_sig_req,
  input  logic                i_sig_b_taken,
  output logic                o_pc_valid,
  output logic [ADDR_LEN-1:0] o_pc,
  output logic                o_pred_taken,
  output logic [ADDR_LEN-1:0] o_pred_target
);
  localparam int TAG_HI = BTB_IDX + TAG_LEN + 1;

  logic [ADDR_LEN-1:0] pc_q, pc_d, dpc_q, dpc_d, ptgt_q, ptgt_d;
  logic                run_q, run_d, dvld_q, dvld_d, ptk_q, ptk_d;
  logic                btb_hit, pred;
  logic [ADDR_LEN-1:0] btb_target, tgt;

  gf_btb #(.ADDR_LEN(ADDR_LEN), .BTB_IDX(BTB_IDX), .TAG_LEN(TAG_LEN)) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_idx    (pc_q[BTB_IDX+1:2]),
    .lk_tag    (pc_q[TAG_HI:BTB_IDX+2]),
    .lk_hit    (btb_hit),
    .lk_target (btb_target),
    .upd_en    (i_upd_valid & i_upd_taken),
    .upd_idx   (i_upd_pc[BTB_IDX+1:2]),
    .upd_tag   (i_upd_pc[TAG_HI:BTB_IDX+2]),
    .upd_target({i_upd_target[ADDR_LEN-1:2], 2'b00})
  );

  logic unused_bits;
  assign unused_bits = ^{i_redirect_pc[1:0], i_upd_pc[ADDR_LEN-1:TAG_HI+1],
                         i_upd_pc[1:0], i_upd_target[1:0]};

  assign pred = btb_hit & i_sig_b_taken;
  assign tgt  = pred ? btb_target : pc_q + ADDR_LEN'(INST_BYTES);

  always_comb begin
    pc_d   = pc_q;
    run_d  = 1'b1;
    dvld_d = dvld_q;
    dpc_d  = dpc_q;
    ptk_d  = ptk_q;
    ptgt_d = ptgt_q;
    if (run_q) begin
      if (i_redirect) begin
        pc_d   = {i_redirect_pc[ADDR_LEN-1:2], 2'b00};
        dvld_d = 1'b0;
      end else if (!i_stall) begin
        pc_d   = tgt;
        dvld_d = 1'b1;
        dpc_d  = pc_q;
        ptk_d  = pred;
        ptgt_d = tgt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      run_q  <= 1'b0;
      dvld_q <= 1'b0;
      dpc_q  <= '0;
      ptk_q  <= 1'b0;
      ptgt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      run_q  <= run_d;
      dvld_q <= dvld_d;
      dpc_q  <= dpc_d;
      ptk_q  <= ptk_d;
      ptgt_q <= ptgt_d;
    end
  end

  assign o_req_inst_addr = pc_q;
  assign o_sig_req       = run_q & ~i_stall & ~i_redirect;
  assign o_pc_valid      = dvld_q;
  assign o_pc            = dpc_q;
  assign o_pred_taken    = ptk_q;
  assign o_pred_target   = ptgt_q;
endmodule

// File: tb/tb_gf_npc.sv
// Directed plus randomized checks of gf_npc against a behavioural fetch/BTB model.
module tb_gf_npc;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_stall = 1'b0, i_redirect = 1'b0, i_upd_valid = 1'b0, i_upd_taken = 1'b0;
  logic        i_sig_b_taken = 1'b0;
  logic [63:0] i_redirect_pc = '0, i_upd_pc = '0, i_upd_target = '0;
  logic [63:0] o_req_inst_addr, o_pc, o_pred_target;
  logic        o_sig_req, o_pc_valid, o_pred_taken;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [63:0] m_pc, m_opc, m_ptgt;
  bit          m_run, m_vld, m_ptk;
  bit          m_bv [64];
  logic [9:0]  m_bt [64];
  logic [63:0] m_btgt [64];

  gf_npc dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc),
    .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
    .o_req_inst_addr(o_req_inst_addr), .o_sig_req(o_sig_req),
    .i_sig_b_taken(i_sig_b_taken), .o_pc_valid(o_pc_valid), .o_pc(o_pc),
    .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [63:0] a);
    return int'((a / 4) % 64);
  endfunction

  function automatic logic [9:0] tag_of(input logic [63:0] a);
    return 10'((a / 256) % 1024);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_run = 0; m_vld = 0; m_opc = '0; m_ptk = 0; m_ptgt = '0;
    for (int i = 0; i < 64; i++) m_bv[i] = 0;
  endtask

  task automatic check_state();
    chk("req_inst_addr", o_req_inst_addr, m_pc);
    chk("pc_valid", 64'(o_pc_valid), 64'(m_vld));
    chk("pc", o_pc, m_opc);
    chk("pred_taken", 64'(o_pred_taken), 64'(m_ptk));
    chk("pred_target", o_pred_target, m_ptgt);
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model, check after the edge.
  task automatic step(input bit st, input bit rd, input logic [63:0] rpc, input bit uv,
                      input logic [63:0] upc, input bit ut, input logic [63:0] utg, input bit pht);
    int          li, ui;
    bit          pred;
    logic [63:0] tgt;
    i_stall = st; i_redirect = rd; i_redirect_pc = rpc; i_upd_valid = uv;
    i_upd_pc = upc; i_upd_taken = ut; i_upd_target = utg; i_sig_b_taken = pht;
    #1;
    chk("sig_req", 64'(o_sig_req), 64'(m_run && !st && !rd));
    li   = idx_of(m_pc);
    pred = m_bv[li] && (m_bt[li] == tag_of(m_pc)) && pht;
    tgt  = pred ? m_btgt[li] : m_pc + 64'd4;
    if (m_run) begin
      if (rd) begin
        m_pc  = rpc & ~64'd3;
        m_vld = 0;
      end else if (!st) begin
        m_opc = m_pc; m_ptk = pred; m_ptgt = tgt; m_pc = tgt; m_vld = 1;
      end
    end
    m_run = 1;
    if (uv && ut) begin
      ui = idx_of(upc);
      m_bv[ui] = 1; m_bt[ui] = tag_of(upc); m_btgt[ui] = utg & ~64'd3;
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic idle(input bit pht);
    step(0, 0, '0, 0, '0, 0, '0, pht);
  endtask

  task automatic rand_step();
    bit st, rd, uv, ut, pht;
    logic [63:0] rpc, upc, utg;
    st  = ($urandom % 100) < 25;
    rd  = ($urandom % 100) < 10;
    rpc = RST_PC + 64'($urandom_range(0, 2047));
    uv  = ($urandom % 100) < 40;
    upc = ($urandom % 2 == 0) ? m_pc : RST_PC + 64'($urandom_range(0, 511) * 4);
    ut  = ($urandom % 4) != 0;
    utg = RST_PC + 64'($urandom_range(0, 2047));
    pht = ($urandom % 2) == 1;
    step(st, rd, rpc, uv, upc, ut, utg, pht);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_state();
    chk("sig_req_in_reset", 64'(o_sig_req), 64'd0);
    rst_n = 1'b1;

    // sequential fetch from reset; install a BTB entry for 8000_0010 along the way
    idle(0);
    step(0, 0, '0, 1, 64'h8000_0010, 1, 64'h8000_0100, 0);
    idle(1); idle(1); idle(1);
    chk("seq_pc_0010", o_req_inst_addr, 64'h8000_0010);
    idle(1);
    chk("btb_jump_pc", o_req_inst_addr, 64'h8000_0100);
    chk("btb_jump_taken", 64'(o_pred_taken), 64'd1);
    chk("btb_jump_target", o_pred_target, 64'h8000_0100);

    // same entry, PHT says not taken
    step(0, 1, 64'h8000_0010, 0, '0, 0, '0, 0);
    idle(0);
    chk("pht_nt_pc", o_req_inst_addr, 64'h8000_0014);
    chk("pht_nt_taken", 64'(o_pred_taken), 64'd0);

    // three-cycle stall, then resume
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0, 0, '0, 0);
    chk("stall_hold_pc", o_req_inst_addr, 64'h8000_0014);
    idle(0);
    chk("resume_pc", o_req_inst_addr, 64'h8000_0018);

    // redirect during a stall, misaligned target
    step(1, 1, 64'h8000_0203, 0, '0, 0, '0, 0);
    chk("redirect_pc", o_req_inst_addr, 64'h8000_0200);
    chk("redirect_squash", 64'(o_pc_valid), 64'd0);

    // PC+4 wrap at the top of the address space
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, 0, '0, 0);
    idle(0);
    chk("wrap_pc", o_req_inst_addr, 64'h0);

    // same-cycle update and lookup of one entry sees the old contents
    step(0, 1, 64'h8000_0300, 0, '0, 0, '0, 0);
    step(0, 0, '0, 1, 64'h8000_0300, 1, 64'h8000_0480, 1);
    chk("same_cycle_upd", o_req_inst_addr, 64'h8000_0304);
    step(0, 1, 64'h8000_0300, 0, '0, 0, '0, 0);
    idle(1);
    chk("after_upd_hit", o_req_inst_addr, 64'h8000_0480);

    for (int i = 0; i < 400; i++) rand_step();

    // asynchronous reset mid-run
    i_stall = 0; i_redirect = 0; i_upd_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sig_req", 64'(o_sig_req), 64'd0);
    chk("rst_pc_valid", 64'(o_pc_valid), 64'd0);
    chk("rst_req_addr", o_req_inst_addr, RST_PC);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_state();
    idle(1); idle(1); idle(1); idle(1); idle(1);
    chk("post_rst_miss", o_req_inst_addr, 64'h8000_0010);

    for (int i = 0; i < 150; i++) rand_step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
